// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions for the interrupt controller slice.
// Contents: interrupt FSM state enum, default IM2 vector base and I/O port
// constants, and decode helpers for the Z80 INTACK / IOWR / IORD strobes.
package z80_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [7:0] VEC_BASE_DEF = 8'hE0;
   localparam logic [7:0] IO_PORT_DEF  = 8'h10;

   // Interrupt acknowledge: M1 together with IORQ
   function automatic logic is_intack(input logic m1_n, input logic iorq_n);
      return !m1_n && !iorq_n;
   endfunction

   function automatic logic is_iowr(input logic m1_n, input logic iorq_n,
                                    input logic wr_n);
      return m1_n && !iorq_n && !wr_n;
   endfunction

   function automatic logic is_iord(input logic m1_n, input logic iorq_n,
                                    input logic rd_n);
      return m1_n && !iorq_n && !rd_n;
   endfunction

endpackage

// File: rtl/z80_int_ctrl_if.sv
// CPU-side bus of the Z80 interrupt controller.
// master: the CPU (drives strobes, address, write data; receives int_n and
//         the data-in bus contribution do_oe/do_data).
// slave : the interrupt controller.
interface z80_int_ctrl_if;
   logic       m1_n;
   logic       iorq_n;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] A;
   logic [7:0] dout;
   logic       int_n;
   logic       do_oe;
   logic [7:0] do_data;

   modport master (
      output m1_n, iorq_n, rd_n, wr_n, A, dout,
      input  int_n, do_oe, do_data
   );

   modport slave (
      input  m1_n, iorq_n, rd_n, wr_n, A, dout,
      output int_n, do_oe, do_data
   );
endinterface

// File: rtl/z80_prio_enc.sv
// Combinational lowest-index priority encoder.
// Ports: req   - request vector (NSRC bits)
//        idx   - index of the lowest set bit (0 when none)
//        valid - at least one request bit set
module z80_prio_enc #(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0] req,
   output logic [2:0]      idx,
   output logic            valid
);

   // Scan downwards so the lowest set index is the last one written
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = 3'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 IM2 interrupt controller.
// Edge-detects NSRC level requests into a pending register, requests the CPU
// via int_n and answers the INTACK cycle with VEC_BASE whose bits [3:1] carry
// the lowest-index pending, unmasked source.
// Ports: clk   - CPU clock
//        reset - synchronous active-high reset
//        irq   - level interrupt sources, synchronous to clk
//        bus   - CPU strobes/address/data, int_n and data-in drive (slave)
// Build option: define Z80_INT_CTRL_IOREG_EN to add the mask/status register
// at IO_PORT and the pending-clear register at IO_PORT+1; without it the mask
// is fixed to all ones and I/O cycles are ignored.
module z80_int_ctrl
   import z80_bus_pkg::*;
#(
   parameter int         NSRC     = 4,
   parameter logic [7:0] VEC_BASE = VEC_BASE_DEF,
   parameter logic [7:0] IO_PORT  = IO_PORT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq,
   z80_int_ctrl_if.slave   bus
);

   state_t          state;
   logic [NSRC-1:0] irq_p1;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] pending_nx;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] win_onehot;
   logic [NSRC-1:0] io_clr;
   logic [2:0]      winner;
   logic [2:0]      enc_idx;
   logic            enc_valid;
   logic            int_r;
   logic            intack;
   logic            ack_end;
   logic            vec_oe;
   logic            iord_sel;
   logic [7:0]      io_rdata;

   assign intack  = is_intack(bus.m1_n, bus.iorq_n);
   assign rise    = irq & ~irq_p1;
   assign active  = pending & mask;
   assign ack_end = (state == ST_ACK) && !intack;

   z80_prio_enc #(.NSRC(NSRC)) u_prio (
      .req   (active),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_comb begin
      win_onehot = '0;
      for (int i = 0; i < NSRC; i++) begin
         win_onehot[i] = (winner == 3'(i));
      end
   end

`ifdef Z80_INT_CTRL_IOREG_EN
   logic       iowr_p1;
   logic       wr_first;
   logic [7:0] mask_x;
   logic [7:0] pend_x;

   // Register writes act on the first clk of the strobe only
   assign wr_first = is_iowr(bus.m1_n, bus.iorq_n, bus.wr_n) && !iowr_p1;
   assign io_clr   = (wr_first && (bus.A == IO_PORT + 8'd1)) ? bus.dout[NSRC-1:0] : '0;
   assign iord_sel = is_iord(bus.m1_n, bus.iorq_n, bus.rd_n) && (bus.A == IO_PORT);
   assign mask_x   = 8'(mask);
   assign pend_x   = 8'(pending);
   assign io_rdata = {mask_x[3:0], pend_x[3:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         iowr_p1 <= 1'b0;
         mask    <= '1;
      end else begin
         iowr_p1 <= is_iowr(bus.m1_n, bus.iorq_n, bus.wr_n);
         if (wr_first && (bus.A == IO_PORT)) begin
            mask <= bus.dout[NSRC-1:0];
         end
      end
   end
`else
   logic unused_bus;

   assign mask       = '1;
   assign io_clr     = '0;
   assign iord_sel   = 1'b0;
   assign io_rdata   = 8'h00;
   assign unused_bus = ^{bus.rd_n, bus.wr_n, bus.A, bus.dout};
`endif

   // A new edge on the winner in the clear clk survives (set applied last)
   always_comb begin
      pending_nx = pending & ~io_clr;
      if (ack_end) begin
         pending_nx = pending_nx & ~win_onehot;
      end
      pending_nx = pending_nx | rise;
   end

   // Stage p1: irq history and pending accumulation
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_p1  <= '0;
         pending <= '0;
      end else begin
         irq_p1  <= irq;
         pending <= pending_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         int_r  <= 1'b1;
         winner <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enc_valid) begin
                  state <= ST_REQ;
                  int_r <= 1'b0;
               end
            end
            ST_REQ: begin
               if (intack && enc_valid) begin
                  winner <= enc_idx;
                  state  <= ST_ACK;
                  int_r  <= 1'b1;
               end else if (!enc_valid) begin
                  state <= ST_IDLE;
                  int_r <= 1'b1;
               end
            end
            ST_ACK: begin
               if (!intack) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               int_r <= 1'b1;
            end
         endcase
      end
   end

   // Vector drive follows INTACK combinationally once in ACK
   assign vec_oe      = (state == ST_ACK) && intack;
   assign bus.int_n   = int_r;
   assign bus.do_oe   = vec_oe || iord_sel;
   assign bus.do_data = vec_oe   ? {VEC_BASE[7:4], winner, VEC_BASE[0]} :
                        iord_sel ? io_rdata : 8'h00;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl (NSRC=4, VEC_BASE=E0, IO_PORT=10).
// Expected vectors come from a small pending/mask model and are queued when
// the INTACK cycle is started, then compared when the DUT drives the bus.
module tb_z80_int_ctrl;
   import z80_bus_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;

   z80_int_ctrl_if bus();

   z80_int_ctrl #(.NSRC(4)) dut (
      .clk   (clk),
      .reset (reset),
      .irq   (irq),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] exp_q[$];
   logic [3:0] exp_pend = 4'h0;
   logic [3:0] exp_mask = 4'hF;
   logic [2:0] exp_win  = 3'd0;
   logic [7:0] last_vec = 8'h00;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] lowest(input logic [3:0] v);
      logic [2:0] w = 3'd0;
      for (int i = 3; i >= 0; i--) if (v[i]) w = 3'(i);
      return w;
   endfunction

   function automatic logic [7:0] vec_of(input logic [2:0] w);
      logic [7:0] v = 8'hE0;
      v[3:1] = w;
      return v;
   endfunction

   task automatic wait_int(input string tag);
      int n = 0;
      while (bus.int_n !== 1'b0 && n < 10) begin
         step();
         n++;
      end
      chk_eq(tag, 32'(bus.int_n), 32'd0);
   endtask

   task automatic intack_begin(input string tag);
      logic [7:0] e;
      exp_win = lowest(exp_pend & exp_mask);
      exp_q.push_back(vec_of(exp_win));
      bus.m1_n   = 1'b0;
      bus.iorq_n = 1'b0;
      step();
      chk_eq({tag, "_int_n"}, 32'(bus.int_n), 32'd1);
      chk_eq({tag, "_oe"}, 32'(bus.do_oe), 32'd1);
      e = exp_q.pop_front();
      last_vec = e;
      chk_eq({tag, "_vec"}, 32'(bus.do_data), 32'(e));
   endtask

   task automatic intack_end();
      bus.m1_n   = 1'b1;
      bus.iorq_n = 1'b1;
      step();
      exp_pend = exp_pend & ~(4'b0001 << exp_win);
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      bus.A      = a;
      bus.dout   = d;
      bus.iorq_n = 1'b0;
      bus.wr_n   = 1'b0;
      step();
      step();
      bus.iorq_n = 1'b1;
      bus.wr_n   = 1'b1;
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      irq        = 4'h0;
      bus.m1_n   = 1'b1;
      bus.iorq_n = 1'b1;
      bus.rd_n   = 1'b1;
      bus.wr_n   = 1'b1;
      bus.A      = 8'h00;
      bus.dout   = 8'h00;
      step();
      step();
      chk_eq("rst_int_n", 32'(bus.int_n), 32'd1);
      chk_eq("rst_oe", 32'(bus.do_oe), 32'd0);
      chk_eq("rst_data", 32'(bus.do_data), 32'h00);
      chk_eq("rst_pending", 32'(dut.pending), 32'h0);
      chk_eq("rst_state", 32'(dut.state), 32'(ST_IDLE));
      reset = 1'b0;
      step();

      // Single source
      irq[2] = 1'b1;
      exp_pend |= 4'b0100;
      wait_int("single_int");
      intack_begin("single");
      step();
      intack_end();
      chk_eq("single_clear", 32'(dut.pending), 32'(exp_pend));
      irq = 4'h0;
      step();

      // Two simultaneous sources, plus a new edge while the first is acked
      irq = 4'b1010;
      exp_pend |= 4'b1010;
      wait_int("prio_int1");
      intack_begin("prio1");
      irq[2] = 1'b1;
      exp_pend |= 4'b0100;
      step();
      chk_eq("prio_hold_vec", 32'(bus.do_data), 32'(last_vec));
      intack_end();
      wait_int("prio_int2");
      intack_begin("prio2");
      intack_end();
      wait_int("prio_int3");
      intack_begin("prio3");
      intack_end();
      chk_eq("prio_empty", 32'(dut.pending), 32'(exp_pend));
      irq = 4'h0;
      step();

      // New edge on the winner in the clear clk keeps it pending
      irq[1] = 1'b1;
      exp_pend |= 4'b0010;
      wait_int("sw_int");
      intack_begin("sw");
      irq[1] = 1'b0;
      step();
      bus.m1_n   = 1'b1;
      bus.iorq_n = 1'b1;
      irq[1]     = 1'b1;
      step();
      chk_eq("sw_pending", 32'(dut.pending), 32'(exp_pend));
      chk_eq("sw_state", 32'(dut.state), 32'(ST_IDLE));
      wait_int("sw_reassert");
      intack_begin("sw2");
      intack_end();
      irq = 4'h0;
      step();

`ifdef Z80_INT_CTRL_IOREG_EN
      io_write(8'h10, 8'h0E);
      exp_mask = 4'hE;
      irq[0] = 1'b1;
      exp_pend |= 4'b0001;
      repeat (5) step();
      chk_eq("mask_int_n", 32'(bus.int_n), 32'd1);
      bus.A      = 8'h10;
      bus.iorq_n = 1'b0;
      bus.rd_n   = 1'b0;
      step();
      chk_eq("ioread_oe", 32'(bus.do_oe), 32'd1);
      chk_eq("ioread_data", 32'(bus.do_data), 32'({exp_mask, exp_pend}));
      bus.iorq_n = 1'b1;
      bus.rd_n   = 1'b1;
      step();
      io_write(8'h11, 8'h01);
      exp_pend &= ~4'b0001;
      chk_eq("ioclr_pending", 32'(dut.pending), 32'(exp_pend));
      io_write(8'h10, 8'h0F);
      exp_mask = 4'hF;
      irq = 4'h0;
      step();
`else
      io_write(8'h10, 8'h00);
      irq[0] = 1'b1;
      exp_pend |= 4'b0001;
      wait_int("io_ignored_int");
      intack_begin("io_ignored");
      intack_end();
      irq = 4'h0;
      bus.A      = 8'h10;
      bus.iorq_n = 1'b0;
      bus.rd_n   = 1'b0;
      step();
      chk_eq("ioread_no_oe", 32'(bus.do_oe), 32'd0);
      bus.iorq_n = 1'b1;
      bus.rd_n   = 1'b1;
      step();
`endif

      // Reset while the vector is on the bus
      irq[3] = 1'b1;
      exp_pend |= 4'b1000;
      wait_int("rst_ack_int");
      intack_begin("rst_ack");
      reset = 1'b1;
      step();
      chk_eq("rst_ack_oe", 32'(bus.do_oe), 32'd0);
      chk_eq("rst_ack_int_n", 32'(bus.int_n), 32'd1);
      chk_eq("rst_ack_pending", 32'(dut.pending), 32'h0);
      chk_eq("rst_ack_state", 32'(dut.state), 32'(ST_IDLE));
      reset      = 1'b0;
      irq        = 4'h0;
      bus.m1_n   = 1'b1;
      bus.iorq_n = 1'b1;
      exp_pend   = 4'h0;
      step();
      step();
      chk_eq("post_rst_int_n", 32'(bus.int_n), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/z80_int_ctrl.md
Z80_INT_CTRL -- requirements
Module: z80_int_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of interrupt sources (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 8'hE0, IM2 vector base; bits [3:1] are replaced by the winning source index.
REQ-003 SHALL have parameter IO_PORT, default 8'h10, I/O address of mask/status register; IO_PORT+1 is the pending-clear register.
REQ-004 SHALL have port clk, input, 1, the single clock, shared with the CPU clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port irq, input, NSRC, level source requests, synchronous to clk.
REQ-007 SHALL have ports m1_n, iorq_n, rd_n, wr_n, input, 1 each, CPU bus strobes.
REQ-008 SHALL have port A, input, 8, CPU address low byte.
REQ-009 SHALL have port dout, input, 8, CPU write data.
REQ-010 SHALL have port int_n, output, 1, registered interrupt request to the CPU.
REQ-011 SHALL have port do_oe, output, 1, high when this block drives the CPU data-in bus.
REQ-012 SHALL have port do_data, output, 8, data to the CPU data-in bus, valid when do_oe=1.

Function
REQ-013 SHALL register irq and set pending[i] on each rising edge of irq[i] (0->1 between consecutive clks).
REQ-014 SHALL define INTACK as m1_n=0 and iorq_n=0; IOWR as iorq_n=0, wr_n=0, m1_n=1; IORD as iorq_n=0, rd_n=0, m1_n=1.
REQ-015 SHALL implement FSM IDLE->REQ->ACK->IDLE.
REQ-016 IDLE: when (pending & mask) != 0, SHALL go to REQ and drive int_n=0 from the next clk.
REQ-017 REQ: SHALL hold int_n=0 until INTACK; if (pending & mask) becomes 0 before INTACK, SHALL return to IDLE with int_n=1.
REQ-018 On the first INTACK clk in REQ, SHALL latch winner = lowest-index set bit of (pending & mask), go to ACK and drive int_n=1.
REQ-019 ACK: SHALL drive do_oe=1 and do_data = VEC_BASE with bits [3:1] = winner while INTACK holds, with zero latency after INTACK is seen.
REQ-020 When INTACK ends, SHALL clear pending[winner] and return to IDLE in the same clk.
REQ-021 A new edge on irq[winner] in the clear clk SHALL leave pending[winner]=1 (set wins).
REQ-022 Edges on other sources during REQ/ACK SHALL be recorded and SHALL NOT change the latched winner.
REQ-023 Sources masked off SHALL still accumulate pending but SHALL NOT cause int_n=0.
REQ-024 Registers SHALL act once per I/O cycle, on the first clk of the IOWR/IORD strobe only.

Reset
REQ-025 On reset=1 at clk: state=IDLE, pending=0, mask=all ones, winner=0, irq history=0, int_n=1, do_oe=0, do_data=8'h00.
REQ-026 Reset mid-REQ or mid-ACK SHALL abandon the cycle, release the bus (do_oe=0) and drop int_n to 1 on the next clk.

Configuration
REQ-027 Macro Z80_INT_CTRL_IOREG_EN SHALL compile in the I/O registers.
REQ-028 With the macro: IOWR to IO_PORT loads mask=dout[NSRC-1:0]; IORD of IO_PORT drives do_oe=1, do_data={mask[3:0],pending[3:0]} zero-extended; IOWR to IO_PORT+1 clears pending bits written 1.
REQ-029 Without the macro: mask is constant all ones, I/O cycles are ignored, and do_oe is asserted only in ACK.

Structure
REQ-030 SHALL place the FSM state enum, the INTACK/IOWR/IORD decode helpers and the default VEC_BASE/IO_PORT constants in shared package z80_bus_pkg.
REQ-031 SHALL instantiate one sub-module, z80_prio_enc, a combinational lowest-index priority encoder (NSRC in, index plus valid out).

Verification
REQ-032 Single source: irq[2] rises, CPU in IM2 with I=8'h80, EI -> int_n=0 one clk later; INTACK reads 8'hE4; pending[2] clears; ISR entered at the address held at 16'h80E4.
REQ-033 Priority: irq[3] and irq[1] rise in the same clk -> first INTACK returns 8'hE2, second returns 8'hE6.
REQ-034 Mask (IOREG_EN): OUT (10h),8'h0E, then irq[0] rises -> int_n stays 1; IN (10h) returns 8'hE1; OUT (11h),8'h01 -> pending=0.
REQ-035 Set-wins boundary: irq[1] rises again in the INTACK-end clk -> pending[1]=1 after the clear and int_n reasserts.
REQ-036 Reset in ACK: reset=1 while INTACK is active -> next clk do_oe=0, int_n=1, pending=0, state=IDLE.
